// File: rtl/fill_fifo_fsm_pkg.sv
// Shared definitions for the scanout fill-FIFO address sequencer.
// Holds the default bus width and the FSM state type.
package fill_fifo_fsm_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/fill_fifo_fsm_if.sv
// Control/geometry bundle between the register block (master) and the
// fill-FIFO sequencer (slave).
interface fill_fifo_fsm_if #(
  parameter int ADDR_W = fill_fifo_fsm_pkg::ADDR_W
);

  logic              start;
  logic              hsync_I;
  logic              vsync_I;
  logic              fill_half_fifo_I;
  logic [ADDR_W-1:0] FRAME_BASE_ADDR;
  logic [ADDR_W-1:0] LINE_STRIDE;
  logic [ADDR_W-1:0] NUM_PIXELS_PER_LINE;
  logic [ADDR_W-1:0] NUM_BYTES_PER_PIXEL;
  logic [ADDR_W-1:0] ddr_addr_to_read;
  logic              go_fill_fifo;

  modport master (
    output start, hsync_I, vsync_I, fill_half_fifo_I,
    output FRAME_BASE_ADDR, LINE_STRIDE, NUM_PIXELS_PER_LINE, NUM_BYTES_PER_PIXEL,
    input  ddr_addr_to_read, go_fill_fifo
  );

  modport slave (
    input  start, hsync_I, vsync_I, fill_half_fifo_I,
    input  FRAME_BASE_ADDR, LINE_STRIDE, NUM_PIXELS_PER_LINE, NUM_BYTES_PER_PIXEL,
    output ddr_addr_to_read, go_fill_fifo
  );

endinterface

// File: rtl/fill_fifo_fsm_rise_pulse.sv
// 1-bit rising-edge detector: pulse is high for the single cycle in which
// din is 1 and was 0 at the previous clock edge.
module rise_pulse (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign pulse = din & ~prev_q;

endmodule

// File: rtl/fill_fifo_fsm.sv
// Scanout DDR read-address sequencer: turns frame/line/half-line sync events
// into a registered burst start address plus a one-cycle fill launch pulse.
module fill_fifo_fsm
  import fill_fifo_fsm_pkg::*;
#(
  parameter int ADDR_W = fill_fifo_fsm_pkg::ADDR_W
) (
  input  logic            clk,
  input  logic            reset,
  fill_fifo_fsm_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              go_q, go_d;

  logic              hsync_ev, vsync_ev, fill_ev;
  logic [ADDR_W-1:0] half_line;
  logic [ADDR_W-1:0] next_line;

  // Half of a line's byte count; the product deliberately keeps only ADDR_W bits.
  function automatic logic [ADDR_W-1:0] half_bytes(input logic [ADDR_W-1:0] npix,
                                                   input logic [ADDR_W-1:0] nbpp);
    logic [ADDR_W-1:0] prod;
    prod = npix * nbpp;
    return prod >> 1;
  endfunction

  rise_pulse u_hsync_edge (
    .clk   (clk),
    .reset (reset),
    .din   (bus.hsync_I),
    .pulse (hsync_ev)
  );

  rise_pulse u_vsync_edge (
    .clk   (clk),
    .reset (reset),
    .din   (bus.vsync_I),
    .pulse (vsync_ev)
  );

  rise_pulse u_fill_edge (
    .clk   (clk),
    .reset (reset),
    .din   (bus.fill_half_fifo_I),
    .pulse (fill_ev)
  );

  assign half_line = half_bytes(bus.NUM_PIXELS_PER_LINE, bus.NUM_BYTES_PER_PIXEL);
  assign next_line = line_base_q + bus.LINE_STRIDE;

  always_comb begin
    state_d     = state_q;
    line_base_d = line_base_q;
    addr_d      = addr_q;
    go_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = ACTIVE;
          line_base_d = bus.FRAME_BASE_ADDR;
          addr_d      = bus.FRAME_BASE_ADDR;
          go_d        = 1'b1;
        end
      end
      ACTIVE: begin
        // Losing simultaneous events are dropped, never queued.
        if (!bus.start) begin
          state_d = IDLE;
        end else if (vsync_ev) begin
          line_base_d = bus.FRAME_BASE_ADDR;
          addr_d      = bus.FRAME_BASE_ADDR;
          go_d        = 1'b1;
        end else if (hsync_ev) begin
          line_base_d = next_line;
          addr_d      = next_line;
          go_d        = 1'b1;
        end else if (fill_ev) begin
          addr_d      = line_base_q + half_line;
          go_d        = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      line_base_q <= '0;
      addr_q      <= '0;
      go_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_base_q <= line_base_d;
      addr_q      <= addr_d;
      go_q        <= go_d;
    end
  end

  assign bus.ddr_addr_to_read = addr_q;
  assign bus.go_fill_fifo     = go_q;

endmodule

// File: tb/tb_fill_fifo_fsm.sv
// Scoreboard bench for fill_fifo_fsm: every expected go pulse is queued with
// its address when the triggering stimulus is driven.
module tb_fill_fifo_fsm;

  localparam logic [31:0] FRAME  = 32'hA800_0000;
  localparam logic [31:0] STRIDE = 32'h0000_0500;
  localparam logic [31:0] HALF   = 32'h0000_0080;

  logic clk;
  logic reset;

  fill_fifo_fsm_if #(.ADDR_W(32)) bus ();

  fill_fifo_fsm #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_hsync(input logic [31:0] exp_addr);
    bus.hsync_I = 1'b1;
    exp_q.push_back(exp_addr);
    step();
    bus.hsync_I = 1'b0;
    step();
  endtask

  task automatic pulse_vsync();
    bus.vsync_I = 1'b1;
    exp_q.push_back(bus.FRAME_BASE_ADDR);
    step();
    bus.vsync_I = 1'b0;
    step();
  endtask

  task automatic pulse_fill(input logic [31:0] exp_addr);
    bus.fill_half_fifo_I = 1'b1;
    exp_q.push_back(exp_addr);
    step();
    bus.fill_half_fifo_I = 1'b0;
    step();
  endtask

  // Scoreboard monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.go_fill_fifo === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_go", 32'd1, 32'd0);
      else chk("go_addr", bus.ddr_addr_to_read, exp_q.pop_front());
    end
  end

  initial begin
    reset                   = 1'b0;
    bus.start               = 1'b0;
    bus.hsync_I             = 1'b0;
    bus.vsync_I             = 1'b0;
    bus.fill_half_fifo_I    = 1'b0;
    bus.FRAME_BASE_ADDR     = FRAME;
    bus.LINE_STRIDE         = STRIDE;
    bus.NUM_PIXELS_PER_LINE = 32'h40;
    bus.NUM_BYTES_PER_PIXEL = 32'd4;

    step(3);
    chk("rst_addr", bus.ddr_addr_to_read, 32'h0);
    chk("rst_go", {31'd0, bus.go_fill_fifo}, 32'd0);
    reset = 1'b1;
    step(2);
    chk("idle_no_go", {31'd0, bus.go_fill_fifo}, 32'd0);

    // Start: one launch at the frame base.
    bus.start = 1'b1;
    exp_q.push_back(FRAME);
    step(3);

    // Seven lines.
    for (int i = 1; i <= 7; i++) pulse_hsync(FRAME + STRIDE * i);
    chk("line7_addr", bus.ddr_addr_to_read, 32'hA800_2300);

    // Line, half-line, then line again proves line_base unchanged by fill.
    pulse_vsync();
    pulse_hsync(FRAME + STRIDE);
    pulse_fill(FRAME + STRIDE + HALF);
    pulse_hsync(FRAME + 2 * STRIDE);
    pulse_vsync();

    // hsync held high: only one event.
    bus.hsync_I = 1'b1;
    exp_q.push_back(FRAME + STRIDE);
    step(5);
    bus.hsync_I = 1'b0;
    step(2);

    // hsync and vsync together: vsync wins.
    bus.hsync_I = 1'b1;
    bus.vsync_I = 1'b1;
    exp_q.push_back(FRAME);
    step();
    bus.hsync_I = 1'b0;
    bus.vsync_I = 1'b0;
    step(2);

    // hsync and fill together: hsync wins, fill dropped.
    bus.hsync_I          = 1'b1;
    bus.fill_half_fifo_I = 1'b1;
    exp_q.push_back(FRAME + STRIDE);
    step();
    bus.hsync_I          = 1'b0;
    bus.fill_half_fifo_I = 1'b0;
    step(2);

    // Back-to-back events: go stays high on consecutive cycles.
    bus.hsync_I = 1'b1;
    exp_q.push_back(FRAME + 2 * STRIDE);
    step();
    bus.hsync_I          = 1'b0;
    bus.fill_half_fifo_I = 1'b1;
    exp_q.push_back(FRAME + 2 * STRIDE + HALF);
    step();
    bus.fill_half_fifo_I = 1'b0;
    step(2);

    // Stop: address holds, events ignored.
    last_addr = bus.ddr_addr_to_read;
    bus.start = 1'b0;
    step(2);
    bus.hsync_I = 1'b1;
    step();
    bus.hsync_I = 1'b0;
    bus.vsync_I = 1'b1;
    step();
    bus.vsync_I = 1'b0;
    step(2);
    chk("hold_addr", bus.ddr_addr_to_read, last_addr);

    // Wrap modulo 2^32 near the top of the address space.
    bus.FRAME_BASE_ADDR = 32'hFFFF_FC00;
    bus.start = 1'b1;
    exp_q.push_back(32'hFFFF_FC00);
    step(2);
    pulse_hsync(32'h0000_0100);
    pulse_fill(32'h0000_0180);

    // Asynchronous reset between hsync pulses.
    bus.FRAME_BASE_ADDR = FRAME;
    pulse_vsync();
    pulse_hsync(FRAME + STRIDE);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_addr", bus.ddr_addr_to_read, 32'h0);
    chk("async_rst_go", {31'd0, bus.go_fill_fifo}, 32'd0);
    step(2);
    // Release with start still high: first cycle is IDLE, then a fresh launch.
    reset = 1'b1;
    exp_q.push_back(FRAME);
    step(3);

    // start=0 with hsync pulses: no launches.
    bus.start = 1'b0;
    step(2);
    for (int i = 0; i < 3; i++) begin
      bus.hsync_I = 1'b1;
      step();
      bus.hsync_I = 1'b0;
      step();
    end
    step(3);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
